// File: rtl/cmd_issue_if.sv
// Scheduler -> issue queue -> DRAM command bus signal bundle.
// Optional statistics signals exist only when CMD_ISSUE_STATS_EN is defined.
interface cmd_issue_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CMD_W  = 4,
    parameter int unsigned ADDR_W = 14
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                     sch_issue;
    logic [CMD_W+ADDR_W-1:0]  sch_out;
    logic                     isu_fifo_full;
    logic                     dram_cmd_valid;
    logic [CMD_W-1:0]         dram_cmd;
    logic [ADDR_W-1:0]        dram_addr;
    logic [CNT_W-1:0]         fifo_count;
`ifdef CMD_ISSUE_STATS_EN
    logic [15:0]              stat_issued;
    logic [15:0]              stat_full_drop;
`endif

    // Scheduler / bus-consumer side
    modport master (
        output sch_issue, sch_out,
        input  isu_fifo_full, dram_cmd_valid, dram_cmd, dram_addr, fifo_count
`ifdef CMD_ISSUE_STATS_EN
        , stat_issued, stat_full_drop
`endif
    );

    // Issue queue side
    modport slave (
        input  sch_issue, sch_out,
        output isu_fifo_full, dram_cmd_valid, dram_cmd, dram_addr, fifo_count
`ifdef CMD_ISSUE_STATS_EN
        , stat_issued, stat_full_drop
`endif
    );
endinterface

// File: rtl/cmd_issue_queue.sv
// In-order issue FIFO between the bank scheduler and the DRAM command bus.
// Each popped command blocks the next pop for its minimum gap (tRCD/burst/tRP/tRFC).
// Optional macro CMD_ISSUE_STATS_EN adds saturating issued / full-drop counters.
module cmd_issue_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CMD_W   = 4,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned T_RCD   = 3,
    parameter int unsigned T_BURST = 4,
    parameter int unsigned T_RP    = 3,
    parameter int unsigned T_RFC   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    cmd_issue_if.slave  bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned GAP_W  = $clog2(T_RFC + 1);
    localparam int unsigned WORD_W = CMD_W + ADDR_W;

    localparam logic [CMD_W-1:0] ATCMD_NOP       = CMD_W'(0);
    localparam logic [CMD_W-1:0] ATCMD_ACTIVE    = CMD_W'(1);
    localparam logic [CMD_W-1:0] ATCMD_READ      = CMD_W'(2);
    localparam logic [CMD_W-1:0] ATCMD_WRITE     = CMD_W'(3);
    localparam logic [CMD_W-1:0] ATCMD_RDA       = CMD_W'(4);
    localparam logic [CMD_W-1:0] ATCMD_WRA       = CMD_W'(5);
    localparam logic [CMD_W-1:0] ATCMD_PRECHARGE = CMD_W'(6);
    localparam logic [CMD_W-1:0] ATCMD_PREA      = CMD_W'(7);
    localparam logic [CMD_W-1:0] ATCMD_REFRESH   = CMD_W'(8);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [GAP_W-1:0]  r_gap;
    logic              r_full;
    logic              r_valid;
    logic [CMD_W-1:0]  r_cmd;
    logic [ADDR_W-1:0] r_addr;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [WORD_W-1:0] w_head;
    logic [CMD_W-1:0]  w_head_cmd;
    logic [ADDR_W-1:0] w_head_addr;

    // Minimum spacing from a command to the next one on the bus
    function automatic int unsigned gap_of(input logic [CMD_W-1:0] c);
        case (c)
            ATCMD_ACTIVE:                                   return T_RCD;
            ATCMD_READ, ATCMD_WRITE, ATCMD_RDA, ATCMD_WRA:  return T_BURST;
            ATCMD_PRECHARGE, ATCMD_PREA:                    return T_RP;
            ATCMD_REFRESH:                                  return T_RFC;
            default:                                        return 1;
        endcase
    endfunction

    assign w_push      = bus.sch_issue && !r_full;
    assign w_pop       = (r_count != CNT_W'(0)) && (r_gap == GAP_W'(0));
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_cmd  = w_head[WORD_W-1:ADDR_W];
    assign w_head_addr = w_head[ADDR_W-1:0];

    // Next occupancy from push/pop combination
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Entry storage; intentionally not cleared by reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.sch_out;
        end
    end

    // Pointers, occupancy, gap timer and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_gap    <= '0;
            r_valid  <= 1'b0;
            r_cmd    <= ATCMD_NOP;
            r_addr   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            if (w_pop) begin
                r_gap <= GAP_W'(gap_of(w_head_cmd) - 1);
            end else if (r_gap != GAP_W'(0)) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            r_valid <= w_pop;
            r_cmd   <= w_pop ? w_head_cmd  : ATCMD_NOP;
            r_addr  <= w_pop ? w_head_addr : '0;
        end
    end

    assign bus.isu_fifo_full  = r_full;
    assign bus.dram_cmd_valid = r_valid;
    assign bus.dram_cmd       = r_cmd;
    assign bus.dram_addr      = r_addr;
    assign bus.fifo_count     = r_count;

`ifdef CMD_ISSUE_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_full_drop;

    // Saturating counts of issued commands and pushes dropped while full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issued    <= '0;
            r_stat_full_drop <= '0;
        end else begin
            if (w_pop && (r_stat_issued != 16'hFFFF)) begin
                r_stat_issued <= r_stat_issued + 16'd1;
            end
            if (bus.sch_issue && r_full && (r_stat_full_drop != 16'hFFFF)) begin
                r_stat_full_drop <= r_stat_full_drop + 16'd1;
            end
        end
    end

    assign bus.stat_issued    = r_stat_issued;
    assign bus.stat_full_drop = r_stat_full_drop;
`endif
endmodule
